// File: rtl/wcsl_keys.sv
// Console key conditioner: per-key debounce FSMs, priority key delivery over valid/ack,
// debounced maintenance switches with change strobe. Auto-repeat under WCSL_KEYS_REPEAT_EN.
module wcsl_keys #(
    parameter logic [15:0] DB_CYCLES     = 16'd50000,
    parameter logic [23:0] REPEAT_CYCLES = 24'd5000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [0:17] ctl1,
    input  logic [0:17] ctl2,
    output logic        key_valid,
    output logic [4:0]  key_code,
    input  logic        key_ack,
    output logic [0:17] sw_out,
    output logic        sw_chg
);

    localparam int NKeys = 18;

    typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StRelWait} key_st_e;

    key_st_e     key_st_q  [NKeys];
    key_st_e     key_st_d  [NKeys];
    logic [15:0] key_cnt_q [NKeys];
    logic [15:0] key_cnt_d [NKeys];
    logic [15:0] sw_cnt_q  [NKeys];
    logic [15:0] sw_cnt_d  [NKeys];
    logic [0:17] key_set;
    logic [0:17] ack_clr;
    logic [0:17] pending_q, pending_d;
    logic [0:17] sw_q, sw_d;
    logic        sw_chg_q, sw_chg_d;
    logic        key_valid_q, key_valid_d;
    logic [4:0]  key_code_q, key_code_d;
    logic [4:0]  first_idx;

`ifdef WCSL_KEYS_REPEAT_EN
    logic [23:0] rpt_q [NKeys];
    logic [23:0] rpt_d [NKeys];
`else
    logic [23:0] unused_repeat_cycles;
    assign unused_repeat_cycles = REPEAT_CYCLES;
`endif

    always_comb begin
        for (int i = 0; i < NKeys; i++) begin
            key_st_d[i]  = key_st_q[i];
            key_cnt_d[i] = key_cnt_q[i];
            key_set[i]   = 1'b0;
            unique case (key_st_q[i])
                StIdle: begin
                    if (ctl1[i]) begin
                        key_st_d[i]  = StPressWait;
                        key_cnt_d[i] = 16'd1;
                    end
                end
                StPressWait: begin
                    if (!ctl1[i]) begin
                        key_st_d[i]  = StIdle;
                        key_cnt_d[i] = '0;
                    end else if (key_cnt_q[i] + 16'd1 >= DB_CYCLES) begin
                        key_st_d[i]  = StHeld;
                        key_cnt_d[i] = '0;
                        key_set[i]   = 1'b1;
                    end else begin
                        key_cnt_d[i] = key_cnt_q[i] + 16'd1;
                    end
                end
                StHeld: begin
                    if (!ctl1[i]) begin
                        key_st_d[i]  = StRelWait;
                        key_cnt_d[i] = 16'd1;
                    end
                end
                StRelWait: begin
                    if (ctl1[i]) begin
                        key_st_d[i]  = StHeld;
                        key_cnt_d[i] = '0;
                    end else if (key_cnt_q[i] + 16'd1 >= DB_CYCLES) begin
                        key_st_d[i]  = StIdle;
                        key_cnt_d[i] = '0;
                    end else begin
                        key_cnt_d[i] = key_cnt_q[i] + 16'd1;
                    end
                end
                default: begin
                    key_st_d[i]  = StIdle;
                    key_cnt_d[i] = '0;
                end
            endcase
`ifdef WCSL_KEYS_REPEAT_EN
            // Only HELD->HELD advances the repeat count; REL_WAIT leaves it frozen.
            rpt_d[i] = rpt_q[i];
            if (key_st_q[i] == StPressWait && key_st_d[i] == StHeld) begin
                rpt_d[i] = '0;
            end else if (key_st_q[i] == StHeld && key_st_d[i] == StHeld) begin
                if (rpt_q[i] + 24'd1 >= REPEAT_CYCLES) begin
                    rpt_d[i]   = '0;
                    key_set[i] = 1'b1;
                end else begin
                    rpt_d[i] = rpt_q[i] + 24'd1;
                end
            end
`endif
        end
    end

    // Switch debounce: counting while raw differs from the debounced level is the
    // PRESS_WAIT/REL_WAIT run, and the debounced level itself is IDLE versus HELD.
    always_comb begin
        sw_d = sw_q;
        for (int i = 0; i < NKeys; i++) begin
            sw_cnt_d[i] = '0;
            if (ctl2[i] != sw_q[i]) begin
                if (sw_cnt_q[i] + 16'd1 >= DB_CYCLES) begin
                    sw_d[i] = ctl2[i];
                end else begin
                    sw_cnt_d[i] = sw_cnt_q[i] + 16'd1;
                end
            end
        end
        sw_chg_d = (sw_d != sw_q);
    end

    always_comb begin
        first_idx = '0;
        for (int i = NKeys - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                first_idx = 5'(i);
            end
        end
    end

    always_comb begin
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        ack_clr     = '0;
        if (key_valid_q) begin
            if (key_ack) begin
                key_valid_d         = 1'b0;
                ack_clr[key_code_q] = 1'b1;
            end
        end else if (|pending_q) begin
            key_valid_d = 1'b1;
            key_code_d  = first_idx;
        end
        // A new set on the bit being acked wins over the clear.
        pending_d = (pending_q & ~ack_clr) | key_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NKeys; i++) begin
                key_st_q[i]  <= StIdle;
                key_cnt_q[i] <= '0;
                sw_cnt_q[i]  <= '0;
`ifdef WCSL_KEYS_REPEAT_EN
                rpt_q[i]     <= '0;
`endif
            end
            pending_q   <= '0;
            sw_q        <= '0;
            sw_chg_q    <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            for (int i = 0; i < NKeys; i++) begin
                key_st_q[i]  <= key_st_d[i];
                key_cnt_q[i] <= key_cnt_d[i];
                sw_cnt_q[i]  <= sw_cnt_d[i];
`ifdef WCSL_KEYS_REPEAT_EN
                rpt_q[i]     <= rpt_d[i];
`endif
            end
            pending_q   <= pending_d;
            sw_q        <= sw_d;
            sw_chg_q    <= sw_chg_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign sw_out    = sw_q;
    assign sw_chg    = sw_chg_q;

endmodule

// File: doc/wcsl_keys.md
# wcsl_keys

Console key conditioner that sits directly downstream of the console switch/light Avalon register block. It consumes the 18-bit key word `ctl1` and maintenance-switch word `ctl2` and debounces each key with a per-key state machine. Debounced key presses are delivered one at a time to the processor console logic over a valid/ack handshake, and the debounced maintenance switches are forwarded with a change strobe.

## Interface
- `DB_CYCLES`, 16'd50000: consecutive stable cycles required to accept a press or a release.
- `REPEAT_CYCLES`, 24'd5000000: auto-repeat period while a key is held; used only with `WCSL_KEYS_REPEAT_EN`.
- `clk` in 1: single clock for everything.
- `reset_n` in 1: asynchronous, active-low reset.
- `ctl1` in [0:17]: raw key word; bit 0 is the MSB and has the highest priority.
- `ctl2` in [0:17]: raw maintenance switch word.
- `key_valid` out 1: a debounced key event is presented.
- `key_code` out 5: index 0–17 of the presented key.
- `key_ack` in 1: consumer accepts the presented key.
- `sw_out` out [0:17]: debounced maintenance switches.
- `sw_chg` out 1: one-cycle strobe when `sw_out` changes.

## Operation
- Inputs are `clk`-synchronous; there is no synchronizer stage.
- Each `ctl1` bit has its own FSM and 16-bit counter. States: IDLE, PRESS_WAIT, HELD, REL_WAIT.
  - IDLE → PRESS_WAIT when the bit is 1; the counter loads 1.
  - PRESS_WAIT: bit 1 increments the counter. When the counter reaches `DB_CYCLES`, go to HELD and set `pending[i]`. Bit 0 returns to IDLE with counter 0.
  - HELD → REL_WAIT when the bit is 0; the counter loads 1.
  - REL_WAIT: bit 0 increments the counter. When the counter reaches `DB_CYCLES`, go to IDLE. Bit 1 returns to HELD.
- A key produces exactly one pending event per press. A glitch shorter than `DB_CYCLES` never produces an event.
- Output stage:
  - When `key_valid`=0 and `pending`≠0, load `key_code` with the lowest set index and set `key_valid`.
  - While `key_valid`=1, `key_code` is frozen. A higher-priority key that becomes pending meanwhile waits.
  - When `key_valid`=1 and `key_ack`=1 at an edge, clear `key_valid` and `pending[key_code]`.
  - `key_ack` while `key_valid`=0 is ignored.
- Setting an already-set pending bit coalesces; there is no counting or queueing per key.
- Maintenance switches: each `ctl2` bit is debounced by the same PRESS/REL rule, with no pending or handshake. `sw_out[i]` updates when its debounce completes. `sw_chg` pulses in the same cycle `sw_out` changes. Simultaneous changes on several bits give a single pulse.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - `key_valid`=0, `key_code`=0, `sw_out`=0, `sw_chg`=0.
  - All FSMs IDLE, all counters 0, `pending`=0.
- Reset mid-debounce or mid-handshake discards all state; an asserted key must be re-debounced after release of reset.
- Press latency: bit first sampled 1 at edge E0 → `pending[i]` set at edge E0+`DB_CYCLES`−1 → `key_valid` high after edge E0+`DB_CYCLES`.
- Ack to next valid: ack at edge A → `key_valid` low after A, high again after A+1 if `pending` is non-zero. There is always at least one cycle with `key_valid`=0 between events.
- Pending set and ack on the same bit in the same cycle cannot occur: re-arm requires a release first, or a repeat period with `WCSL_KEYS_REPEAT_EN`. If it does occur under repeat, the set wins.
- Counters saturate at `DB_CYCLES` and never wrap.

## Configuration
- `WCSL_KEYS_REPEAT_EN` defined:
  - Each key gets a 24-bit repeat counter, cleared on entry to HELD.
  - In HELD the counter increments. On reaching `REPEAT_CYCLES` it sets `pending[i]` and reloads 0.
  - REL_WAIT freezes the repeat counter; returning to HELD resumes it.
- Undefined: no repeat logic or counters are built, and a held key yields exactly one event.

## Test plan
- `DB_CYCLES`=4, raise `ctl1[3]` for 10 cycles → `key_valid`=1 with `key_code`=3 four cycles after first sample. Ack → `key_valid`=0. No further event until release plus 4 stable low cycles and a new press.
- Pulse `ctl1[5]` high for 3 cycles with `DB_CYCLES`=4 → no `key_valid`. Then a 1-cycle low glitch in a held key's REL_WAIT → no second event.
- Press `ctl1[7]`, then `ctl1[2]` while 7 is presented unacked → `key_code` stays 7 until ack. One idle cycle later `key_code`=2.
- Press `ctl1[0]` and `ctl1[17]` in the same cycle → 0 delivered first, then 17. Ack in the idle cycle is ignored.
- Flip `ctl2` to 18'o000042 → `sw_out`=18'o000042 and one `sw_chg` pulse `DB_CYCLES` cycles later. Assert `reset_n`=0 mid-debounce → all outputs 0 immediately.
- With `WCSL_KEYS_REPEAT_EN` and `REPEAT_CYCLES`=10, hold `ctl1[4]` for 40 cycles, acking promptly → one initial event plus 3 repeats, each `key_code`=4.
